// File: rtl/spi_sched_pkg.sv
// Shared types and default sizes for the SPI transaction scheduler.
// Optional watchdog is enabled with SPI_SCHED_TIMEOUT_EN.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CFG_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: scans requests from ptr upward with wrap.
// The pointer register lives in the parent.
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    logic [IW:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (!valid && req[pos[IW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one spi_module between NUM_REQ requesters.
// Define SPI_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CFG_W       = DEF_CFG_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_err,
    output logic                      o_busy,
    output logic [DATA_W-1:0]         o_spi_data,
    output logic [CFG_W-1:0]          o_spi_cfg,
    output logic                      o_spi_trans_en,
    input  logic                      i_spi_interrupt,
    input  logic [DATA_W-1:0]         i_spi_data
);

    localparam int IW = $clog2(NUM_REQ);

    state_e              state;
    state_e              state_nx;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic [DATA_W-1:0]   data_q;
    logic [CFG_W-1:0]    cfg_q;
    logic [DATA_W-1:0]   rsp_q;
    logic                err_q;
    logic                int_q;
    logic                edge_hit;
    logic                tmo_hit;

    spi_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (i_req),
        .ptr  (ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .valid(arb_valid)
    );

    assign edge_hit = (state == WAIT) && i_spi_interrupt && !int_q;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wd_cnt;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            wd_cnt <= '0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == WAIT) && (wd_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_valid) state_nx = LOAD;
            LOAD:    state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (edge_hit || tmo_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            data_q <= '0;
            cfg_q  <= '0;
            rsp_q  <= '0;
            err_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            state <= state_nx;
            int_q <= i_spi_interrupt;
            if (state == IDLE && arb_valid) begin
                win    <= arb_idx;
                data_q <= i_req_data[int'(arb_idx)*DATA_W +: DATA_W];
                cfg_q  <= i_req_cfg[int'(arb_idx)*CFG_W +: CFG_W];
            end
            // A real edge always beats a coincident timeout.
            if (edge_hit) begin
                rsp_q <= i_spi_data;
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                rsp_q <= '0;
                err_q <= 1'b1;
            end
            if (state == DONE) begin
                ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Grant is combinational from i_req, so mask it while reset is held.
    assign o_gnt          = (state == IDLE && i_sys_rst) ? arb_gnt : '0;
    assign o_done         = (state == DONE) ? (NUM_REQ'(1) << win) : '0;
    assign o_err          = (state == DONE) && err_q;
    assign o_busy         = (state != IDLE);
    assign o_spi_trans_en = (state == START);
    assign o_spi_data     = data_q;
    assign o_spi_cfg      = cfg_q;
    assign o_rsp_data     = rsp_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed self-checking bench for spi_txn_scheduler with a small SPI core model.
module tb_spi_txn_scheduler;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        logic [7:0] d;
        logic [7:0] c;
        logic       e;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [31:0] req_cfg;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rsp;
    logic        err;
    logic        busy;
    logic [7:0]  spi_data;
    logic [7:0]  spi_cfg;
    logic        trans_en;
    logic        spi_int;
    logic [7:0]  spi_rx;

    logic        model_on;
    int          dly;
    logic        force_en;
    logic        force_int;
    logic [7:0]  force_data;

    logic        mdl_int;
    logic [7:0]  mdl_data;
    logic [7:0]  cap;
    logic        armed;
    int          cnt;
    int          hi;

    int cyc = 0;
    logic int_prev = 1'b0;
    ev_t gq[$];
    ev_t tq[$];
    ev_t dq[$];
    int  iq[$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_txn_scheduler #(
        .NUM_REQ(4),
        .DATA_W(8),
        .CFG_W(8),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst_n),
        .i_req(req),
        .i_req_data(req_data),
        .i_req_cfg(req_cfg),
        .o_gnt(gnt),
        .o_done(done),
        .o_rsp_data(rsp),
        .o_err(err),
        .o_busy(busy),
        .o_spi_data(spi_data),
        .o_spi_cfg(spi_cfg),
        .o_spi_trans_en(trans_en),
        .i_spi_interrupt(spi_int),
        .i_spi_data(spi_rx)
    );

    assign spi_int = force_en ? force_int : mdl_int;
    assign spi_rx  = force_en ? force_data : mdl_data;

    // SPI core model: interrupt rises dly cycles after trans_en, high for 2 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            cnt      <= 0;
            hi       <= 0;
            mdl_int  <= 1'b0;
            mdl_data <= 8'h00;
            cap      <= 8'h00;
        end else begin
            if (mdl_int) begin
                if (hi >= 2) mdl_int <= 1'b0;
                hi <= hi + 1;
            end
            if (armed) cnt <= cnt + 1;
            if (armed && cnt == dly - 1) begin
                mdl_int  <= 1'b1;
                hi       <= 1;
                mdl_data <= cap ^ 8'hFF;
                armed    <= 1'b0;
            end
            if (trans_en && model_on) begin
                cap <= spi_data;
                cnt <= 1;
                if (dly == 1) begin
                    mdl_int  <= 1'b1;
                    hi       <= 1;
                    mdl_data <= spi_data ^ 8'hFF;
                    armed    <= 1'b0;
                end else begin
                    armed <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gnt != 4'b0) gq.push_back(ev_t'{cyc, gnt, 8'h00, 8'h00, 1'b0});
        if (trans_en) tq.push_back(ev_t'{cyc, 4'b0, spi_data, spi_cfg, 1'b0});
        if (done != 4'b0) dq.push_back(ev_t'{cyc, done, rsp, 8'h00, err});
        if (spi_int && !int_prev) iq.push_back(cyc);
        int_prev <= spi_int;
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return gq.size();
            1:       return tq.size();
            default: return dq.size();
        endcase
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == (4'b1 << i)) return i;
        return -1;
    endfunction

    task automatic wait_ev(input int which, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (qsize(which) >= n) break;
            @(negedge clk);
            #1;
        end
        ok = (qsize(which) >= n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        req = 4'hF;
        #1;
        total++;
        if (gnt !== 4'b0) begin
            bad++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if ({done, err, trans_en} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000000", {done, err, trans_en});
        end
        total++;
        if ({spi_data, spi_cfg, rsp} !== 24'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 000000", {spi_data, spi_cfg, rsp});
        end
        req = 4'b0;
    endtask

    task automatic test_single();
        bit ok;
        int g0, t0, d0, i0;
        do_reset();
        model_on = 1'b1;
        dly = 20;
        req_data[7:0] = 8'hA5;
        req_cfg[7:0]  = 8'h03;
        g0 = gq.size(); t0 = tq.size(); d0 = dq.size(); i0 = iq.size();
        req = 4'b0001;
        wait_ev(0, g0 + 1, 10, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        wait_ev(2, d0 + 1, 60, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL single_wait: got %0d dones want %0d", dq.size() - d0, 1);
        end else begin
            total++;
            if (gq[g0].v !== 4'b0001) begin
                bad++;
                $display("FAIL single_gnt: got %b want 0001", gq[g0].v);
            end
            total++;
            if (tq[t0].cyc - gq[g0].cyc !== 2) begin
                bad++;
                $display("FAIL single_lat: got %0d want 2", tq[t0].cyc - gq[g0].cyc);
            end
            total++;
            if ({tq[t0].d, tq[t0].c} !== 16'hA503) begin
                bad++;
                $display("FAIL single_out: got %h want a503", {tq[t0].d, tq[t0].c});
            end
            total++;
            if (iq.size() <= i0 || dq[d0].cyc - iq[i0] !== 1) begin
                bad++;
                $display("FAIL single_done_lat: got done at %0d want one after edge", dq[d0].cyc);
            end
            total++;
            if (dq[d0].cyc - tq[t0].cyc !== 21) begin
                bad++;
                $display("FAIL single_te_done: got %0d want 21", dq[d0].cyc - tq[t0].cyc);
            end
            total++;
            if ({dq[d0].v, dq[d0].d, dq[d0].e} !== {4'b0001, 8'h5A, 1'b0}) begin
                bad++;
                $display("FAIL single_done: got %b/%h/%b want 0001/5a/0", dq[d0].v, dq[d0].d, dq[d0].e);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (rsp !== 8'h5A) begin
            bad++;
            $display("FAIL single_hold: got %h want 5a", rsp);
        end
    endtask

    task automatic test_all4();
        bit ok;
        int g0, d0, k;
        logic [7:0] want;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_on = 1'b1;
        dly = 1;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'h10 + 8'(i);
            req_cfg[i*8 +: 8]  = 8'h20 + 8'(i);
        end
        req = 4'hF;
        g0 = gq.size(); d0 = dq.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ev(2, d0 + 5, 80, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL all4_wait: got %0d dones want 5", dq.size() - d0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                k = i % 4;
                want = (8'h10 + 8'(k)) ^ 8'hFF;
                total++;
                if (oh2i(gq[g0+i].v) !== k) begin
                    bad++;
                    $display("FAIL all4_order[%0d]: got %0d want %0d", i, oh2i(gq[g0+i].v), k);
                end
                total++;
                if (dq[d0+i].v !== gq[g0+i].v) begin
                    bad++;
                    $display("FAIL all4_done[%0d]: got %b want %b", i, dq[d0+i].v, gq[g0+i].v);
                end
                total++;
                if (dq[d0+i].d !== want) begin
                    bad++;
                    $display("FAIL all4_rsp[%0d]: got %h want %h", i, dq[d0+i].d, want);
                end
            end
            total++;
            if (gq[g0+1].cyc - gq[g0].cyc !== 5) begin
                bad++;
                $display("FAIL all4_gap: got %0d want 5", gq[g0+1].cyc - gq[g0].cyc);
            end
        end
    endtask

    task automatic test_no_starve();
        bit ok;
        int g0, t0, d0;
        do_reset();
        dly = 6;
        req_data[23:16] = 8'h33;
        req_data[15:8]  = 8'h44;
        g0 = gq.size(); t0 = tq.size(); d0 = dq.size();
        req = 4'b0100;
        wait_ev(1, t0 + 1, 20, ok);
        @(posedge clk);
        #1;
        req = 4'b0110;
        wait_ev(2, d0 + 3, 100, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL starve_wait: got %0d dones want 3", dq.size() - d0);
        end else begin
            total++;
            if ({oh2i(gq[g0].v), oh2i(gq[g0+1].v), oh2i(gq[g0+2].v)} !== {32'd2, 32'd1, 32'd2}) begin
                bad++;
                $display("FAIL starve_order: got %0d,%0d,%0d want 2,1,2",
                         oh2i(gq[g0].v), oh2i(gq[g0+1].v), oh2i(gq[g0+2].v));
            end
            total++;
            if ({dq[d0].d, dq[d0+1].d} !== 16'hCCBB) begin
                bad++;
                $display("FAIL starve_rsp: got %h want ccbb", {dq[d0].d, dq[d0+1].d});
            end
            total++;
            if (gq[g0+1].cyc <= dq[d0].cyc) begin
                bad++;
                $display("FAIL starve_busy_gnt: got gnt at %0d want after %0d", gq[g0+1].cyc, dq[d0].cyc);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int g0, t0, d0;
        do_reset();
        dly = 30;
        req_data[7:0] = 8'h5C;
        req_cfg[7:0]  = 8'h0F;
        t0 = tq.size();
        req = 4'b0001;
        wait_ev(1, t0 + 1, 20, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, spi_data} !== {1'b1, 8'h5C}) begin
            bad++;
            $display("FAIL midrst_pre: got %b/%h want 1/5c", busy, spi_data);
        end
        rst_n = 1'b0;
        req = 4'b0001;
        #1;
        total++;
        if ({gnt, done, err, busy, trans_en} !== 11'b0) begin
            bad++;
            $display("FAIL midrst_ctl: got %b want all 0", {gnt, done, err, busy, trans_en});
        end
        total++;
        if ({spi_data, spi_cfg, rsp} !== 24'h0) begin
            bad++;
            $display("FAIL midrst_data: got %h want 000000", {spi_data, spi_cfg, rsp});
        end
        d0 = dq.size();
        repeat (3) @(posedge clk);
        #1;
        req = 4'b1000;
        req_data[31:24] = 8'h77;
        rst_n = 1'b1;
        g0 = gq.size();
        wait_ev(2, d0 + 1, 80, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL midrst_wait: got %0d dones want 1", dq.size() - d0);
        end else begin
            total++;
            if ({gq[g0].v, dq[d0].v, dq[d0].d} !== {4'b1000, 4'b1000, 8'h88}) begin
                bad++;
                $display("FAIL midrst_serve: got %b/%b/%h want 1000/1000/88", gq[g0].v, dq[d0].v, dq[d0].d);
            end
        end
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (dq.size() !== d0 + 1) begin
            bad++;
            $display("FAIL midrst_extra: got %0d dones want 1", dq.size() - d0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t0, d0;
        model_on = 1'b0;
        req_data[7:0] = 8'h66;
        t0 = tq.size(); d0 = dq.size();
        req = 4'b0001;
        wait_ev(1, t0 + 1, 20, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        wait_ev(2, d0 + 1, 40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL tmo_wait: got %0d dones want 1", dq.size() - d0);
        end else begin
            total++;
            if (dq[d0].cyc - tq[t0].cyc !== 17) begin
                bad++;
                $display("FAIL tmo_lat: got %0d want 17", dq[d0].cyc - tq[t0].cyc);
            end
            total++;
            if ({dq[d0].v, dq[d0].e, dq[d0].d} !== {4'b0001, 1'b1, 8'h00}) begin
                bad++;
                $display("FAIL tmo_done: got %b/%b/%h want 0001/1/00", dq[d0].v, dq[d0].e, dq[d0].d);
            end
        end
        model_on = 1'b1;
        dly = 16;
        req_data[7:0] = 8'h19;
        t0 = tq.size(); d0 = dq.size();
        @(posedge clk);
        #1;
        req = 4'b0001;
        wait_ev(1, t0 + 1, 20, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        wait_ev(2, d0 + 1, 40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL tie_wait: got %0d dones want 1", dq.size() - d0);
        end else begin
            total++;
            if ({dq[d0].cyc - tq[t0].cyc, dq[d0].e, dq[d0].d} !== {32'd17, 1'b0, 8'hE6}) begin
                bad++;
                $display("FAIL tie_done: got %0d/%b/%h want 17/0/e6",
                         dq[d0].cyc - tq[t0].cyc, dq[d0].e, dq[d0].d);
            end
        end
`else
        repeat (40) @(negedge clk);
        #1;
        total++;
        if ({busy, err} !== 2'b10) begin
            bad++;
            $display("FAIL notmo_busy: got %b want 10", {busy, err});
        end
        total++;
        if (dq.size() !== d0) begin
            bad++;
            $display("FAIL notmo_done: got %0d dones want 0", dq.size() - d0);
        end
`endif
    endtask

    task automatic test_int_held();
        bit ok;
        int t0, d0, i0;
        do_reset();
        model_on = 1'b0;
        force_en = 1'b1;
        force_int = 1'b1;
        force_data = 8'hC3;
        req_data[7:0] = 8'h21;
        t0 = tq.size(); d0 = dq.size();
        @(posedge clk);
        #1;
        req = 4'b0001;
        wait_ev(1, t0 + 1, 20, ok);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (7) @(negedge clk);
        #1;
        total++;
        if ({busy, 32'(dq.size() - d0)} !== {1'b1, 32'd0}) begin
            bad++;
            $display("FAIL held_nodone: got busy=%b dones=%0d want 1/0", busy, dq.size() - d0);
        end
        @(posedge clk);
        #1;
        force_int = 1'b0;
        i0 = iq.size();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dq.size() !== d0) begin
            bad++;
            $display("FAIL held_fall: got %0d dones want 0", dq.size() - d0);
        end
        force_int = 1'b1;
        wait_ev(2, d0 + 1, 20, ok);
        total++;
        if (ok !== 1'b1 || iq.size() <= i0) begin
            bad++;
            $display("FAIL held_wait: got %0d dones want 1", dq.size() - d0);
        end else begin
            total++;
            if ({dq[d0].cyc - iq[i0], dq[d0].v, dq[d0].d} !== {32'd1, 4'b0001, 8'hC3}) begin
                bad++;
                $display("FAIL held_done: got %0d/%b/%h want 1/0001/c3",
                         dq[d0].cyc - iq[i0], dq[d0].v, dq[d0].d);
            end
        end
        force_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0;
        req_data = 32'h0;
        req_cfg = 32'h0;
        model_on = 1'b1;
        dly = 20;
        force_en = 1'b0;
        force_int = 1'b0;
        force_data = 8'h00;
        test_reset();
        test_single();
        test_all4();
        test_no_starve();
        test_mid_reset();
        test_timeout();
        test_int_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
